// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out prefetch (one slot per 8-pixel group) plus host writes, 1 bpp serialiser.
// Optional VGA_FB_BLANK_WRITE_EN restricts host writes to vertical blanking.
module vga_fb_arbiter #(
    parameter int RES_H  = 640,
    parameter int RES_V  = 480,
    parameter int ADDR_W = 16
) (
    input  logic              PIXEL_CLK,
    input  logic              RESET,
    input  logic [12:0]       locX,
    input  logic [12:0]       locY,
    input  logic              in_image,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              pix_out,
    output logic              pix_valid
);

    localparam int                W       = RES_H / 8;
    localparam logic [9:0]        LAST_G  = 10'(W - 1);
    localparam logic [12:0]       RES_H13 = 13'(RES_H);
    localparam logic [12:0]       RES_V13 = 13'(RES_V);
    localparam logic [13:0]       RES_V14 = 14'(RES_V);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [9:0]        grp;
    logic [2:0]        phase;
    logic [13:0]       y_next;
    logic              fetch_slot;
    logic              last_grp;
    logic              fetch_rd;
    logic              wr_window;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] line_base;
    logic [12:0]       y_prev;
    logic              rd_vld_p1;
    logic [7:0]        next_word;
    logic [7:0]        pix_sr;

    assign grp    = locX[12:3];
    assign phase  = locX[2:0];
    assign y_next = {1'b0, locY} + 14'd1;

    assign fetch_slot = (locX < RES_H13) && (phase == 3'd6);
    assign last_grp   = (grp == LAST_G);
    // The last group of every line (blank lines too) prefetches the first word of the following line.
    assign fetch_rd   = fetch_slot && (last_grp || (locY < RES_V13));

    always_comb begin
        fetch_addr = line_base + ADDR_W'(grp) + ONE_A;
        if (last_grp) begin
            fetch_addr = (y_next < RES_V14) ? (line_base + W_A) : '0;
        end
    end

`ifdef VGA_FB_BLANK_WRITE_EN
    assign wr_window = (locY >= RES_V13);
`else
    assign wr_window = 1'b1;
`endif

    always_comb begin
        wr_ready  = !fetch_rd && wr_window;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (fetch_rd) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (wr_ready && wr_valid) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end
    end

    // Line base follows locY without a multiplier; left out of reset so it keeps tracking the scan through a mid-frame reset.
    always_ff @(posedge PIXEL_CLK) begin
        y_prev <= locY;
        if (locY == '0) begin
            line_base <= '0;
        end else if (locY != y_prev) begin
            line_base <= line_base + W_A;
        end
    end

    // Stage p1: capture fetched word; serialise on group boundaries.
    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            rd_vld_p1 <= 1'b0;
            next_word <= 8'h00;
            pix_sr    <= 8'h00;
            pix_out   <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            rd_vld_p1 <= fetch_rd;
            if (rd_vld_p1) begin
                next_word <= mem_rdata;
            end
            pix_valid <= in_image;
            if (in_image && (phase == 3'd0)) begin
                pix_sr  <= next_word;
                pix_out <= next_word[7];
            end else if (in_image) begin
                pix_sr  <= {pix_sr[6:0], 1'b0};
                pix_out <= pix_sr[6];
            end else begin
                pix_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: arbitration vector table, stall/blank-line sequences and a pixel scoreboard over a scan.
module tb_vga_fb_arbiter;

    localparam int RES_H  = 640;
    localparam int RES_V  = 480;
    localparam int ADDR_W = 16;
    localparam int W      = RES_H / 8;
    localparam int HT     = 648;
    localparam int NWORDS = W * RES_V;

    logic              clk = 1'b0;
    logic              rst;
    logic [12:0]       locX, locY;
    logic              in_image, wr_valid, wr_ready;
    logic [ADDR_W-1:0] wr_addr, mem_addr;
    logic [7:0]        wr_data, mem_wdata, mem_rdata;
    logic              mem_en, mem_we, pix_out, pix_valid;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.RES_H(RES_H), .RES_V(RES_V), .ADDR_W(ADDR_W)) dut (
        .PIXEL_CLK(clk), .RESET(rst), .locX(locX), .locY(locY), .in_image(in_image),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_valid(pix_valid)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 29) ^ 8'(a >> 6) ^ 8'h5A;
    endfunction

    // Single-port synchronous RAM, preloaded with pat() on the first edge.
    logic [7:0] ram [0:65535];
    logic       ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    logic [7:0] gold [0:NWORDS-1];

    typedef struct { int x; int y; logic vld; logic pix; } pix_exp_t;
    pix_exp_t sbq[$];
    logic sb_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   zero_y  = -1;
    int   zero_lo = 0;
    int   zero_hi = -1;

    typedef struct {
        int x; int y; logic wv; logic [15:0] wa; logic [7:0] wd;
        logic rdy; logic en; logic we; logic [15:0] addr;
    } vec_t;
    vec_t vt [15];

    function automatic logic gold_pix(input int x, input int y);
        logic [7:0] w;
        w = gold[y * W + x / 8];
        return w[7 - (x % 8)];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One scan cycle: score the previous cycle's pixel, drive this cycle, queue its expected pixel.
    task automatic step(input int x, input int y, input logic wv, input logic [15:0] wa,
                        input logic [7:0] wd, input logic r);
        pix_exp_t e;
        @(posedge clk); #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("pix(%0d,%0d)", e.x, e.y), {30'd0, pix_valid, pix_out}, {30'd0, e.vld, e.pix});
        end
        locX = 13'(x); locY = 13'(y);
        in_image = (x < RES_H) && (y < RES_V);
        wr_valid = wv; wr_addr = wa; wr_data = wd; rst = r;
        e.x = x; e.y = y; e.vld = 1'b0; e.pix = 1'b0;
        if (!r && in_image) begin
            e.vld = 1'b1;
            e.pix = (y == zero_y && x >= zero_lo && x <= zero_hi) ? 1'b0 : gold_pix(x, y);
        end
        if (sb_on) sbq.push_back(e);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int reads, rd_addr, rd_x, lows, stalls, bad;
        logic rdy, en, we;

        for (int a = 0; a < NWORDS; a++) gold[a] = pat(a);

        rst = 1'b1; locX = '0; locY = 13'd500; in_image = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset pix_out", {31'd0, pix_out}, 32'd0);
        check("reset pix_valid", {31'd0, pix_valid}, 32'd0);

        vt[0]  = '{0,   0,   1'b0, 16'hFFF0, 8'h3C, 1'b1, 1'b0, 1'b0, 16'hFFF0};
        vt[1]  = '{6,   0,   1'b1, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0001};
        vt[2]  = '{7,   0,   1'b1, 16'hFFF0, 8'h3C, 1'b1, 1'b1, 1'b1, 16'hFFF0};
        vt[3]  = '{630, 0,   1'b0, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h004F};
        vt[4]  = '{638, 0,   1'b1, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0050};
        vt[5]  = '{639, 0,   1'b1, 16'hFFF0, 8'h3C, 1'b1, 1'b1, 1'b1, 16'hFFF0};
        vt[6]  = '{646, 0,   1'b1, 16'hFFF0, 8'h3C, 1'b1, 1'b1, 1'b1, 16'hFFF0};
        vt[7]  = '{3,   1,   1'b0, 16'hFFF0, 8'h3C, 1'b1, 1'b0, 1'b0, 16'hFFF0};
        vt[8]  = '{14,  1,   1'b0, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0052};
        vt[9]  = '{638, 1,   1'b1, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h00A0};
        vt[10] = '{638, 479, 1'b1, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[11] = '{6,   490, 1'b1, 16'hFF00, 8'h81, 1'b1, 1'b1, 1'b1, 16'hFF00};
        vt[12] = '{638, 490, 1'b1, 16'hFFF0, 8'h3C, 1'b0, 1'b1, 1'b0, 16'h0000};
        vt[13] = '{630, 490, 1'b0, 16'hFFF0, 8'h3C, 1'b1, 1'b0, 1'b0, 16'hFFF0};
        vt[14] = '{100, 200, 1'b1, 16'hFFF0, 8'h3C, 1'b1, 1'b1, 1'b1, 16'hFFF0};

        for (int i = 0; i < 15; i++) begin
            step(vt[i].x, vt[i].y, vt[i].wv, vt[i].wa, vt[i].wd, 1'b0);
            in_image = 1'b0;
            rdy = vt[i].rdy; en = vt[i].en; we = vt[i].we;
`ifdef VGA_FB_BLANK_WRITE_EN
            if (vt[i].y < RES_V && rdy) begin rdy = 1'b0; en = 1'b0; we = 1'b0; end
`endif
            #1;
            check($sformatf("vec%0d arb", i), {13'd0, wr_ready, mem_en, mem_we, mem_addr},
                  {13'd0, rdy, en, we, vt[i].addr});
            if (we) check($sformatf("vec%0d wdata", i), {24'd0, mem_wdata}, {24'd0, vt[i].wd});
        end

`ifndef VGA_FB_BLANK_WRITE_EN
        stalls = 0; bad = 0;
        for (int x = 0; x < HT; x++) begin
            step(x, 2, 1'b1, 16'hFFF0, 8'h00, 1'b0);
            if (!wr_ready) stalls++;
            if (wr_ready !== !((x < RES_H) && (x % 8 == 6))) bad++;
        end
        check("active line stall count", stalls, 80);
        check("active line stall positions", bad, 0);
`else
        bad = 0;
        for (int x = 0; x < 16; x++) begin
            step(x, 200, 1'b1, 16'hFFF0, 8'h00, 1'b0);
            if (wr_ready !== 1'b0) bad++;
        end
        check("blank-only writes held off", bad, 0);
        step(0, 480, 1'b1, 16'hFFF0, 8'h00, 1'b0);
        check("blank-only first accept", {30'd0, wr_ready, mem_we}, 32'd3);
`endif

        reads = 0; rd_addr = -1; rd_x = -1; lows = 0;
        for (int x = 0; x < HT; x++) begin
            step(x, 490, 1'b1, 16'hFFF0, 8'h00, 1'b0);
            if (!wr_ready) lows++;
            if (mem_en && !mem_we) begin reads++; rd_addr = int'(mem_addr); rd_x = x; end
        end
        check("blank line read count", reads, 1);
        check("blank line read addr", rd_addr, 0);
        check("blank line read x", rd_x, 638);
        check("blank line stall count", lows, 1);

        // Host writes on a blank line, then a scored scan from the last blank lines into line 100.
        sb_on = 1'b1;
        for (int x = 0; x < HT; x++) begin
            if (x == 0)      step(x, 520, 1'b1, 16'h0000, 8'hA5, 1'b0);
            else if (x == 1) step(x, 520, 1'b1, 16'h0001, 8'hFF, 1'b0);
            else             step(x, 520, 1'b0, 16'h0000, 8'h00, 1'b0);
            if (x < 2) check($sformatf("host write %0d accepted", x), {31'd0, wr_ready}, 32'd1);
        end
        gold[0] = 8'hA5;
        gold[1] = 8'hFF;
        for (int y = 521; y < 525; y++)
            for (int x = 0; x < HT; x++) step(x, y, 1'b0, 16'h0000, 8'h00, 1'b0);
        zero_y = 100; zero_lo = 300; zero_hi = 311;
        for (int y = 0; y <= 100; y++)
            for (int x = 0; x < HT; x++)
                step(x, y, 1'b0, 16'h0000, 8'h00, (y == 100 && x >= 300 && x <= 302));
        sb_on = 1'b0;
        step(0, 101, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("scoreboard drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a host pixel writer. The block sits between `vga_sync` and the RAM. It takes the `locX`/`locY`/`in_image` scan position, reserves one RAM slot per 8-pixel group for scan-out prefetch, and grants every other cycle to a valid/ready write port. Fetched words are serialised into a 1 bpp pixel stream aligned to the scan position.

## Interface
- `RES_H`, default 640, active pixels per line; must be a multiple of 8.
- `RES_V`, default 480, active lines per frame.
- `ADDR_W`, default 16, RAM word-address width; must satisfy RES_H/8*RES_V ≤ 2^ADDR_W.
- `PIXEL_CLK` in 1: pixel clock, the only clock.
- `RESET` in 1: asynchronous, active-high reset.
- `locX` in 13: horizontal scan count from `vga_sync`.
- `locY` in 13: vertical scan count from `vga_sync`.
- `in_image` in 1: active-region flag from `vga_sync`.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: write is accepted this cycle.
- `wr_addr` in ADDR_W: host word address.
- `wr_data` in 8: host word; bit 7 is the leftmost pixel.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid one cycle after a read.
- `pix_out` out 1: serialised pixel, registered.
- `pix_valid` out 1: `in_image` delayed by one cycle, registered.

## Operation
- Group index g = locX>>3; phase p = locX[2:0]; W = RES_H/8.
- Fetch slot: cycle with locX < RES_H and p == 6.
  - If g < W-1 and locY < RES_V: read word locY*W + g+1.
  - If g == W-1, on every line including vertical blank: read word ny*W + 0, where ny = locY+1 if locY+1 < RES_V, else 0.
  - Fetch slots with g < W-1 and locY ≥ RES_V issue no read and are free for writes.
- In a fetch read: mem_en=1, mem_we=0, mem_addr=fetch address, and `wr_ready` is 0.
- Every other cycle: wr_ready=1. If wr_valid is high, then mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; otherwise mem_en=0.
- Writes are fire-and-forget; there is no write response.
- The address is computed without a multiplier, using a line-base register advanced by W.
- Read capture: on the edge after a fetch cycle, mem_rdata is latched into `next_word`.
- Serialiser, on each edge:
  - If in_image and p == 0: load the shift register from `next_word`; pix_out ← next_word[7].
  - Else if in_image: shift left; pix_out ← the next bit.
  - Else: pix_out ← 0.
- `pix_valid` ← in_image on every edge.
- Out-of-range host addresses (≥ W*RES_V) are written to the RAM as given; the block does not check them.

## Timing
- Reset values: pix_out=0, pix_valid=0, next_word=0x00, shift register=0x00.
- Outputs that are combinational and do not depend on reset: mem_en, mem_we, mem_addr, mem_wdata, wr_ready.
- Pixel latency: pix_out for scan position (x,y) appears one PIXEL_CLK after `locX`=x, `locY`=y is presented.
- Fetch-to-use: a word fetched at p=6 is captured at p=7 and loaded at the next group's p=0.
- Line 0 group 0 is fetched on the last vertical-blank line at x=RES_H-2.
- Reset deasserted mid-frame: pixels read 0 until the first group whose fetch slot occurred after reset. No other recovery is required.
- Simultaneous fetch slot and wr_valid: the fetch always wins. The write stalls with wr_ready=0 and must be held stable by the host.

## Configuration
- Macro: `VGA_FB_BLANK_WRITE_EN`.
- Defined: wr_ready is also forced to 0 whenever locY < RES_V, so writes are accepted only during vertical blanking. This gives tear-free updates.
- Undefined: writes are accepted in any non-fetch cycle, as described above.

## Test plan
- Host writes 0xA5 to word 0 and 0xFF to word 1 during blank → line 0 pixels 0–7 are 1,0,1,0,0,1,0,1 and pixels 8–15 are all 1, each one cycle after the matching locX.
- Hold wr_valid high continuously over one full line → wr_ready is 0 exactly at locX = 6, 14, …, 638. This gives 80 stalls per active line.
- On a vertical-blank line (locY = 490) → only locX = 638 issues a read, at mem_addr = 0. All other p=6 slots accept writes.
- At locY = 479, locX = 638 → mem_addr = 0 (frame wrap, not 480*80).
- Assert RESET at locX = 300, locY = 100 and release after 3 cycles → pix_out stays 0 through group 38 and shows RAM contents from group 39 onward.
- With `VGA_FB_BLANK_WRITE_EN` defined, wr_valid held at locY = 200 → wr_ready stays 0 until locY = 480, then the first non-fetch cycle accepts the write.
